// File: rtl/mac4591_acc_if.sv
// Beat/result bus of the 4591 multiply-accumulate block. The input beat and
// result handshakes share one bundle; the accumulator takes the slave side.
interface mac4591_acc_if #(
  parameter int ACC_W = 28,
  parameter int CNT_W = 10
);
  logic                    In_valid;
  logic                    In_ready;
  logic signed [12:0]      In_a;
  logic signed [12:0]      In_b;
  logic                    In_first;
  logic                    In_last;
  logic                    Out_valid;
  logic                    Out_ready;
  logic signed [ACC_W-1:0] Out_sum;
  logic [CNT_W-1:0]        Out_count;
  logic                    Out_ovf;

  modport master (
    output In_valid, In_a, In_b, In_first, In_last, Out_ready,
    input  In_ready, Out_valid, Out_sum, Out_count, Out_ovf
  );

  modport slave (
    input  In_valid, In_a, In_b, In_first, In_last, Out_ready,
    output In_ready, Out_valid, Out_sum, Out_count, Out_ovf
  );
endinterface

// File: rtl/mac4591_acc.sv
// Signed dot-product accumulator: registered product stage, wrapping accumulate
// stage, and a held result that blocks new beats until it is taken.
module mac4591_acc #(
  parameter int ACC_W = 28,
  parameter int CNT_W = 10
) (
  input  logic Clk,
  input  logic Reset,
  mac4591_acc_if.slave Bus,
  output logic Err
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t stateReg, stateNext;
  logic accept, effFirst, errSet, handshake;

  logic signed [25:0]      prodReg;
  logic                    prodValidReg, prodFirstReg, prodLastReg;
  logic signed [ACC_W-1:0] accReg;
  logic [CNT_W-1:0]        cntReg, cntNext;
  logic                    ovfReg, ovfNext;
  logic signed [ACC_W:0]   sumWide;

  logic                    outValidReg, outOvfReg, errReg;
  logic signed [ACC_W-1:0] outSumReg;
  logic [CNT_W-1:0]        outCountReg;

  assign accept    = Bus.In_valid & Bus.In_ready;
  assign handshake = outValidReg & Bus.Out_ready;

  always_comb begin
    stateNext    = stateReg;
    Bus.In_ready = 1'b1;
    effFirst     = Bus.In_first;
    errSet       = 1'b0;
    case (stateReg)
      IDLE: begin
        // A stray continuation beat with nothing open starts a new sequence.
        effFirst = 1'b1;
        errSet   = accept & ~Bus.In_first;
        if (accept) stateNext = Bus.In_last ? HOLD : ACCUM;
      end
      ACCUM: begin
        errSet = accept & Bus.In_first;
        if (accept) stateNext = Bus.In_last ? HOLD : ACCUM;
      end
      HOLD: begin
        Bus.In_ready = 1'b0;
        if (handshake) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    sumWide = (prodFirstReg ? '0 : {accReg[ACC_W-1], accReg})
            + {{(ACC_W-25){prodReg[25]}}, prodReg};
    ovfNext = (prodFirstReg ? 1'b0 : ovfReg) | (sumWide[ACC_W] ^ sumWide[ACC_W-1]);
    if (prodFirstReg)  cntNext = CNT_W'(1);
    else if (&cntReg)  cntNext = cntReg;
    else               cntNext = cntReg + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stateReg     <= IDLE;
      prodReg      <= '0;
      prodValidReg <= 1'b0;
      prodFirstReg <= 1'b0;
      prodLastReg  <= 1'b0;
      accReg       <= '0;
      cntReg       <= '0;
      ovfReg       <= 1'b0;
      outValidReg  <= 1'b0;
      outSumReg    <= '0;
      outCountReg  <= '0;
      outOvfReg    <= 1'b0;
      errReg       <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      prodValidReg <= accept;
      if (accept) begin
        prodReg      <= Bus.In_a * Bus.In_b;
        prodFirstReg <= effFirst;
        prodLastReg  <= Bus.In_last;
      end
      if (prodValidReg) begin
        accReg <= sumWide[ACC_W-1:0];
        cntReg <= cntNext;
        ovfReg <= ovfNext;
      end
      // HOLD blocks new beats, so a new result never collides with a pending one.
      if (prodValidReg && prodLastReg) begin
        outValidReg <= 1'b1;
        outSumReg   <= sumWide[ACC_W-1:0];
        outCountReg <= cntNext;
        outOvfReg   <= ovfNext;
      end else if (handshake) begin
        outValidReg <= 1'b0;
      end
      if (errSet) errReg <= 1'b1;
    end
  end

  assign Bus.Out_valid = outValidReg;
  assign Bus.Out_sum   = outSumReg;
  assign Bus.Out_count = outCountReg;
  assign Bus.Out_ovf   = outOvfReg;
  assign Err           = errReg;
endmodule

// File: tb/tb_mac4591_acc.sv
// Directed bench for mac4591_acc: a table of beats with expected results,
// followed by latency, backpressure, protocol-error and reset sequences.
module tb_mac4591_acc;
  logic Clk = 1'b0;
  logic Reset;
  logic Err;

  always #5 Clk = ~Clk;

  mac4591_acc_if bus ();
  mac4591_acc dut (.Clk(Clk), .Reset(Reset), .Bus(bus), .Err(Err));

  typedef struct {
    int     a;
    int     b;
    bit     first;
    bit     last;
    longint expSum;
    int     expCount;
    bit     expOvf;
  } vec_t;

  vec_t vecs[16];
  int   nVec;
  int   vecCount  = 0;
  int   missCount = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vecCount++;
    if (act != exp) begin
      missCount++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sendBeat(input int a, input int b, input bit f, input bit l);
    int waitCnt;
    waitCnt = 0;
    @(negedge Clk);
    bus.In_a     = a[12:0];
    bus.In_b     = b[12:0];
    bus.In_first = f;
    bus.In_last  = l;
    bus.In_valid = 1'b1;
    while (!bus.In_ready && waitCnt < 50) begin
      @(negedge Clk);
      waitCnt++;
    end
    if (!bus.In_ready) check("in_ready_timeout", 0, 1);
    @(posedge Clk);
    #1 bus.In_valid = 1'b0;
  endtask

  task automatic waitResult(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk);
      if (bus.Out_valid) got = 1'b1;
    end
    if (!got) check("out_valid_timeout", 0, 1);
  endtask

  task automatic expectResult(input string tag, input longint s, input int c, input bit o);
    bit got;
    waitResult(got);
    if (got) begin
      check({tag, "_sum"}, bus.Out_sum, s);
      check({tag, "_count"}, longint'(bus.Out_count), c);
      check({tag, "_ovf"}, longint'(bus.Out_ovf), o);
      $display("%s: sum=%0d count=%0d ovf=%0d", tag, bus.Out_sum, bus.Out_count, bus.Out_ovf);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;

    nVec = 0;
    vecs[nVec++] = '{2295, 2295, 1'b1, 1'b1, 5267025, 1, 1'b0};
    vecs[nVec++] = '{100, -7, 1'b1, 1'b0, 0, 0, 1'b0};
    vecs[nVec++] = '{-2295, 2295, 1'b0, 1'b0, 0, 0, 1'b0};
    vecs[nVec++] = '{5, 5, 1'b0, 1'b1, -5267700, 3, 1'b0};
    for (int k = 0; k < 8; k++)
      vecs[nVec++] = '{-4096, -4096, (k == 0), (k == 7), -134217728, 8, 1'b1};
    vecs[nVec++] = '{1, 1, 1'b1, 1'b1, 1, 1, 1'b0};
    vecs[nVec++] = '{4095, -4096, 1'b1, 1'b0, 0, 0, 1'b0};
    vecs[nVec++] = '{4095, 4095, 1'b0, 1'b1, -4095, 2, 1'b0};

    bus.In_valid  = 1'b0;
    bus.In_a      = '0;
    bus.In_b      = '0;
    bus.In_first  = 1'b0;
    bus.In_last   = 1'b0;
    bus.Out_ready = 1'b1;
    Reset         = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_out_valid", longint'(bus.Out_valid), 0);
    check("rst_out_sum", bus.Out_sum, 0);
    check("rst_out_count", longint'(bus.Out_count), 0);
    check("rst_out_ovf", longint'(bus.Out_ovf), 0);
    check("rst_err", longint'(Err), 0);
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    check("rst_in_ready", longint'(bus.In_ready), 1);

    // Table of beats; results checked on each closing beat.
    for (int i = 0; i < nVec; i++) begin
      sendBeat(vecs[i].a, vecs[i].b, vecs[i].first, vecs[i].last);
      if (vecs[i].last)
        expectResult($sformatf("vec%0d", i), vecs[i].expSum, vecs[i].expCount, vecs[i].expOvf);
    end
    check("table_err", longint'(Err), 0);

    // Exact two-cycle latency, one-cycle valid, In_ready low while pending.
    sendBeat(2295, 2295, 1'b1, 1'b1);
    @(negedge Clk);
    check("lat_valid_t1", longint'(bus.Out_valid), 0);
    check("lat_ready_t1", longint'(bus.In_ready), 0);
    @(negedge Clk);
    check("lat_valid_t2", longint'(bus.Out_valid), 1);
    check("lat_sum", bus.Out_sum, 5267025);
    @(negedge Clk);
    check("lat_valid_t3", longint'(bus.Out_valid), 0);
    check("lat_ready_t3", longint'(bus.In_ready), 1);
    $display("latency: sum=5267025 valid for one cycle");

    // Backpressure: result held, new beat refused until the handshake.
    bus.Out_ready = 1'b0;
    sendBeat(3, 5, 1'b1, 1'b1);
    waitResult(got);
    bus.In_a     = 13'sd7;
    bus.In_b     = 13'sd7;
    bus.In_first = 1'b1;
    bus.In_last  = 1'b1;
    bus.In_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", longint'(bus.Out_valid), 1);
      check("bp_sum", bus.Out_sum, 15);
      check("bp_count", longint'(bus.Out_count), 1);
      check("bp_ready", longint'(bus.In_ready), 0);
      @(negedge Clk);
    end
    bus.Out_ready = 1'b1;
    @(negedge Clk);
    check("bp_valid_after", longint'(bus.Out_valid), 0);
    check("bp_ready_after", longint'(bus.In_ready), 1);
    @(posedge Clk);
    #1 bus.In_valid = 1'b0;
    expectResult("bp_next", 49, 1, 1'b0);

    // Continuation beat with no open sequence, then a restart mid-sequence.
    sendBeat(6, 7, 1'b0, 1'b0);
    check("proto_err_idle", longint'(Err), 1);
    sendBeat(2, 3, 1'b0, 1'b1);
    expectResult("proto_idle", 48, 2, 1'b0);
    sendBeat(10, 10, 1'b1, 1'b0);
    sendBeat(1, 2, 1'b1, 1'b1);
    expectResult("proto_restart", 2, 1, 1'b0);
    check("proto_err_sticky", longint'(Err), 1);

    // Reset after two of four beats discards the partial sequence.
    sendBeat(1, 1, 1'b1, 1'b0);
    sendBeat(2, 2, 1'b0, 1'b0);
    Reset = 1'b0;
    @(posedge Clk);
    #1 Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check("mid_rst_no_valid", longint'(bus.Out_valid), 0);
    end
    check("mid_rst_err", longint'(Err), 0);
    sendBeat(3, 4, 1'b1, 1'b1);
    expectResult("post_rst", 12, 1, 1'b0);
    check("post_rst_err", longint'(Err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule

// File: doc/mac4591_acc.md
MAC4591_ACC -- requirements
Module: mac4591_acc

Interface
REQ-001 Parameter: ACC_W, 28, accumulator and result width in bits (signed); matches the 28-bit signed input of the downstream 4591 reducer.
REQ-002 Parameter: CNT_W, 10, width of the per-result term counter.
REQ-003 Port: Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-low reset; sampled on the Clk rising edge.
REQ-005 Port: In_valid  input  1  input beat valid.
REQ-006 Port: In_ready  output  1  block accepts a beat this cycle.
REQ-007 Port: In_a  input  13  signed operand A (Rq coefficient).
REQ-008 Port: In_b  input  13  signed operand B.
REQ-009 Port: In_first  input  1  beat opens a new dot-product sequence.
REQ-010 Port: In_last  input  1  beat closes the sequence; In_first and In_last may both be high.
REQ-011 Port: Out_valid  output  1  result valid; held until handshake.
REQ-012 Port: Out_ready  input  1  downstream accepts the result.
REQ-013 Port: Out_sum  output  ACC_W  signed accumulated sum of products, fed to the reducer input.
REQ-014 Port: Out_count  output  CNT_W  number of terms in the result.
REQ-015 Port: Out_ovf  output  1  accumulation left the ACC_W signed range during this sequence.
REQ-016 Port: Err  output  1  sticky protocol-error flag.

Function
REQ-017 Accept = In_valid & In_ready; beats with In_valid low are ignored and change no state.
REQ-018 FSM states: IDLE (no open sequence), ACCUM (sequence open), HOLD (result pending).
REQ-019 In_ready = 1 in IDLE and ACCUM and 0 in HOLD.
REQ-020 Transitions: IDLE to ACCUM on an accepted beat without In_last; IDLE or ACCUM to HOLD on an accepted beat with In_last; HOLD to IDLE in the cycle where Out_valid & Out_ready.
REQ-021 Stage 1: on accept, register the full-precision signed product In_a*In_b (26 bits, sign-extended) with its first and last flags and a product-valid bit.
REQ-022 Stage 2: when the product is valid, acc <= (first ? 0 : acc) + product, computed in ACC_W+1 bits and truncated to ACC_W bits (two's-complement wrap).
REQ-023 Overflow: set the per-sequence flag when bits [ACC_W] and [ACC_W-1] of any stage-2 sum differ; clear it on a first beat before evaluating that beat.
REQ-024 On a stage-2 last beat: load Out_sum with the new acc, Out_count with the term count, and Out_ovf with the sequence overflow flag; set Out_valid = 1.
REQ-025 Latency: last beat accepted in cycle t gives Out_valid = 1 in cycle t+2.
REQ-026 Out_sum, Out_count, and Out_ovf are stable while Out_valid = 1 and Out_ready = 0.
REQ-027 Out_valid clears in the cycle after the handshake; In_ready returns to 1 in that same cycle.
REQ-028 Term counter: reset to 1 on a first beat, otherwise increment; saturate at 2^CNT_W-1.
REQ-029 Accepted beat in ACCUM with In_first = 1: restart accumulation from this beat and set Err.
REQ-030 Accepted beat in IDLE with In_first = 0: treat it as a first beat and set Err.
REQ-031 Err clears only on reset.

Reset
REQ-032 Reset = 0 at a rising edge puts the FSM in IDLE.
REQ-033 On reset: clear acc, the product register, the product-valid bit, and the counter; drive Out_valid, Out_sum, Out_count, Out_ovf, and Err to 0.
REQ-034 In_ready = 1 in the first cycle after reset is released.
REQ-035 Reset mid-sequence or in HOLD discards the partial or pending result; no Out_valid is produced for it.

Verification
REQ-036 Single beat: In_a = 2295, In_b = 2295, first = last = 1, Out_ready = 1 -> Out_sum = 5267025, Out_count = 1, Out_ovf = 0, Out_valid high exactly 2 cycles after accept for 1 cycle.
REQ-037 Three beats (100,-7), (-2295,2295), (5,5) -> Out_sum = -5267700, Out_count = 3; In_ready = 0 from the cycle after the last accept until the handshake.
REQ-038 Backpressure: hold Out_ready = 0 for 5 cycles after Out_valid rises -> outputs stable, In_ready = 0, offered beats not accepted; Out_ready = 1 -> handshake, In_ready = 1 in the next cycle.
REQ-039 Overflow: 8 beats of (-4096,-4096) -> Out_sum = -134217728, Out_ovf = 1; a following single beat (1,1) -> Out_sum = 1, Out_ovf = 0.
REQ-040 Protocol and reset: a non-first beat in IDLE -> Err = 1 and accumulation starts from that beat; Reset = 0 after 2 of 4 beats -> no Out_valid, and a fresh sequence (3,4) first+last -> Out_sum = 12, Err = 0.
